// File: rtl/nco_sweep_ctrl_if.sv
// Control/status bundle between the sweep controller and its user/NCO.
// Inputs to the controller end in _i, outputs from it end in _o.
interface nco_sweep_ctrl_if;
    logic        start_i;
    logic        abort_i;
    logic [31:0] phi_start_i;
    logic [31:0] phi_step_i;
    logic [15:0] num_steps_i;
    logic [15:0] dwell_i;
    logic [7:0]  settle_i;
    logic        nco_valid_i;
    logic [31:0] phi_inc_o;
    logic        nco_clken_o;
    logic        sample_en_o;
    logic [15:0] step_idx_o;
    logic        busy_o;
    logic        done_o;

    modport slave (
        input  start_i, abort_i, phi_start_i, phi_step_i, num_steps_i,
               dwell_i, settle_i, nco_valid_i,
        output phi_inc_o, nco_clken_o, sample_en_o, step_idx_o, busy_o, done_o
    );

    modport master (
        output start_i, abort_i, phi_start_i, phi_step_i, num_steps_i,
               dwell_i, settle_i, nco_valid_i,
        input  phi_inc_o, nco_clken_o, sample_en_o, step_idx_o, busy_o, done_o
    );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Steps an NCO phase increment through N frequencies: settle cycles, then a dwell counted in valid samples.
// Registered outputs (sample_en_o combinational); NCO valid gaps stretch the dwell, abort wins over completion.
module nco_sweep_ctrl (
    input  logic            clk,
    input  logic            reset_n,
    nco_sweep_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_DWELL  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] phi_inc_q, phi_inc_d;
    logic [31:0] phi_step_q, phi_step_d;
    logic [15:0] step_idx_q, step_idx_d;
    logic [15:0] last_idx_q, last_idx_d;
    logic [15:0] dwell_q, dwell_d;
    logic [15:0] dwell_cnt_q, dwell_cnt_d;
    logic [7:0]  settle_q, settle_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic        done_q, done_d;

    always_comb begin
        state_d      = state_q;
        phi_inc_d    = phi_inc_q;
        phi_step_d   = phi_step_q;
        step_idx_d   = step_idx_q;
        last_idx_d   = last_idx_q;
        dwell_d      = dwell_q;
        dwell_cnt_d  = dwell_cnt_q;
        settle_d     = settle_q;
        settle_cnt_d = settle_cnt_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    // Counts are stored as "remaining minus one" so a zero config means one.
                    phi_step_d   = bus.phi_step_i;
                    last_idx_d   = (bus.num_steps_i == 16'd0) ? 16'd0 : bus.num_steps_i - 16'd1;
                    dwell_d      = (bus.dwell_i == 16'd0) ? 16'd0 : bus.dwell_i - 16'd1;
                    settle_d     = bus.settle_i;
                    phi_inc_d    = bus.phi_start_i;
                    step_idx_d   = 16'd0;
                    settle_cnt_d = bus.settle_i;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort_i) begin
                    state_d = S_IDLE;
                end else if (settle_cnt_q == 8'd0) begin
                    dwell_cnt_d = dwell_q;
                    state_d     = S_DWELL;
                end else begin
                    settle_cnt_d = settle_cnt_q - 8'd1;
                end
            end
            S_DWELL: begin
                if (bus.abort_i) begin
                    state_d = S_IDLE;
                end else if (bus.nco_valid_i) begin
                    if (dwell_cnt_q != 16'd0) begin
                        dwell_cnt_d = dwell_cnt_q - 16'd1;
                    end else if (step_idx_q == last_idx_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        phi_inc_d    = phi_inc_q + phi_step_q;
                        step_idx_d   = step_idx_q + 16'd1;
                        settle_cnt_d = settle_q;
                        state_d      = S_SETTLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            phi_inc_q    <= 32'd0;
            phi_step_q   <= 32'd0;
            step_idx_q   <= 16'd0;
            last_idx_q   <= 16'd0;
            dwell_q      <= 16'd0;
            dwell_cnt_q  <= 16'd0;
            settle_q     <= 8'd0;
            settle_cnt_q <= 8'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phi_inc_q    <= phi_inc_d;
            phi_step_q   <= phi_step_d;
            step_idx_q   <= step_idx_d;
            last_idx_q   <= last_idx_d;
            dwell_q      <= dwell_d;
            dwell_cnt_q  <= dwell_cnt_d;
            settle_q     <= settle_d;
            settle_cnt_q <= settle_cnt_d;
            done_q       <= done_d;
        end
    end

    assign bus.phi_inc_o   = phi_inc_q;
    assign bus.step_idx_o  = step_idx_q;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.nco_clken_o = (state_q != S_IDLE);
    assign bus.done_o      = done_q;
    assign bus.sample_en_o = (state_q == S_DWELL) && bus.nco_valid_i;
endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start_i, input, 1 bit: single-cycle sweep request; sampled only in IDLE.
REQ-004 SHALL have port abort_i, input, 1 bit: stops an active sweep.
REQ-005 SHALL have port phi_start_i, input, 32 bits: first phase increment; latched on an accepted start.
REQ-006 SHALL have port phi_step_i, input, 32 bits: two's-complement increment delta; latched on an accepted start.
REQ-007 SHALL have port num_steps_i, input, 16 bits: number of frequencies; 0 is treated as 1.
REQ-008 SHALL have port dwell_i, input, 16 bits: valid NCO samples per frequency; 0 is treated as 1.
REQ-009 SHALL have port settle_i, input, 8 bits: discard cycles after each increment change.
REQ-010 SHALL have port nco_valid_i, input, 1 bit: out_valid from the NCO.
REQ-011 SHALL have port phi_inc_o, output, 32 bits: drives the NCO phi_inc_i.
REQ-012 SHALL have port nco_clken_o, output, 1 bit: drives the NCO clken.
REQ-013 SHALL have port sample_en_o, output, 1 bit: marks NCO samples inside the dwell window.
REQ-014 SHALL have port step_idx_o, output, 16 bits: index of the current frequency, starting at 0.
REQ-015 SHALL have port busy_o, output, 1 bit: high when state is not IDLE.
REQ-016 SHALL have port done_o, output, 1 bit: one-cycle pulse on normal sweep completion.

Function
REQ-017 SHALL implement an FSM with states IDLE, SETTLE and DWELL; all outputs are registered except sample_en_o.
REQ-018 In IDLE, with start_i=1 and abort_i=0, SHALL latch the config, load phi_inc_o with phi_start_i, clear step_idx_o, load the settle counter with settle_i, and enter SETTLE on the next cycle.
REQ-019 SHALL ignore start_i outside IDLE; latched config SHALL be immune to input changes during a sweep.
REQ-020 In SETTLE, SHALL go to DWELL (dwell counter loaded) when the settle counter is 0, else decrement; SETTLE SHALL occupy exactly settle_i+1 cycles, independent of nco_valid_i.
REQ-021 In DWELL, SHALL decrement the dwell counter only on cycles with nco_valid_i=1; gaps in valid SHALL extend the dwell.
REQ-022 sample_en_o SHALL be combinational: (state==DWELL) & nco_valid_i.
REQ-023 On the last counted sample with step_idx_o < N-1: phi_inc_o <= phi_inc_o + phi_step (mod 2^32, wraps silently); step_idx_o increments; settle reloads; next state is SETTLE.
REQ-024 On the last counted sample with step_idx_o == N-1: next state is IDLE and done_o=1 for exactly that next cycle.
REQ-025 nco_clken_o SHALL equal busy_o and SHALL be low in IDLE.
REQ-026 abort_i=1 in SETTLE or DWELL SHALL force IDLE next cycle with no done_o; abort SHALL win over simultaneous completion; abort in IDLE SHALL be a no-op and SHALL block a same-cycle start.
REQ-027 phi_inc_o and step_idx_o SHALL hold their last values in IDLE after completion or abort.
REQ-028 Per-frequency busy time with continuous valid SHALL be settle_i+1+dwell_eff cycles.

Reset
REQ-029 reset_n low SHALL immediately force IDLE with phi_inc_o=0, step_idx_o=0, nco_clken_o=0, busy_o=0 and done_o=0; sample_en_o is 0 as a consequence.
REQ-030 Reset asserted mid-sweep SHALL discard the sweep; there SHALL be no done_o after release, and the block SHALL wait for a new start_i.

Verification
REQ-031 Basic sweep: phi_start=0x3FEF9DB2, step=0x00100000, N=3, dwell=4, settle=2, valid held 1 -> phi_inc_o = 0x3FEF9DB2, 0x3FFF9DB2, 0x400F9DB2; each step gives 3 settle cycles then 4 sample_en_o; busy for 21 cycles; done_o in cycle 22 with busy_o=0.
REQ-032 Wrap and negative step: start=0xFFFFFFF0, step=0x20, N=2 -> second value 0x00000010; start=0x00010000, step=0xFFFF0000, N=2 -> second value 0x00000000.
REQ-033 Gapped valid: dwell=3, settle=0, N=1, valid pattern 1,0,1,0,1 -> exactly 3 sample_en_o pulses; DWELL lasts 5 cycles; done_o follows.
REQ-034 Abort in the same cycle as the final sample of the last step -> IDLE, no done_o, phi_inc_o holds, nco_clken_o=0 the next cycle; start_i while busy -> no effect.
REQ-035 Zero config: N=0, dwell=0, settle=0 -> one frequency, one sample_en_o, done_o 3 cycles after start.
REQ-036 reset_n pulsed low during DWELL of step 1 -> all outputs at reset values within the same cycle; no done_o after release.
